// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: single-cycle multiply, accumulate and move ops,
// plus a multi-cycle restoring divider (DIV_ITER quotient bits per cycle).
module hilo_muldiv_unit #(
    parameter int unsigned DIV_ITER = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [5:0]  opcode,
    input  logic        issue,
    output logic [31:0] result,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        ALU_Stall,
    output logic        done
);

    localparam int unsigned DivCycles = 32 / DIV_ITER;
    localparam logic [5:0] LastCnt = 6'(DivCycles - 1);

    localparam logic [5:0] OpDiv     = 6'd5;
    localparam logic [5:0] OpDivu    = 6'd6;
    localparam logic [5:0] OpMadd    = 6'd7;
    localparam logic [5:0] OpMaddu   = 6'd8;
    localparam logic [5:0] OpMfhi    = 6'd9;
    localparam logic [5:0] OpMflo    = 6'd10;
    localparam logic [5:0] OpMthi    = 6'd11;
    localparam logic [5:0] OpMtlo    = 6'd12;
    localparam logic [5:0] OpMsub    = 6'd13;
    localparam logic [5:0] OpMsubu   = 6'd14;
    localparam logic [5:0] OpMult    = 6'd16;
    localparam logic [5:0] OpMultu   = 6'd17;
    localparam logic [5:0] OpExStall = 6'd33;
    localparam logic [5:0] OpExFlush = 6'd34;

    typedef enum logic [1:0] {StIdle, StDivBusy, StDivFix} state_e;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic        stall_q, done_q, done_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [5:0]  cnt_q, cnt_d;

    logic        is_stall, is_flush;
    logic [63:0] prod_s, prod_u, acc;
    logic [31:0] step_rem, step_quo, quo_fix, rem_fix;
    logic        a_neg, b_neg;

    assign is_stall = issue && (opcode == OpExStall);
    assign is_flush = issue && (opcode == OpExFlush);
    assign prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u   = {32'd0, A} * {32'd0, B};
    assign acc      = {hi_q, lo_q};
    assign quo_fix  = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

    // Restoring division: DIV_ITER shift/subtract steps on the magnitudes
    always_comb begin
        logic [32:0] trial;
        trial    = '0;
        step_rem = rem_q;
        step_quo = quo_q;
        for (int i = 0; i < int'(DIV_ITER); i++) begin
            trial = {step_rem, step_quo[31]} - {1'b0, dvs_q};
            if (!trial[32]) begin
                step_rem = trial[31:0];
                step_quo = {step_quo[30:0], 1'b1};
            end else begin
                step_rem = {step_rem[30:0], step_quo[31]};
                step_quo = {step_quo[30:0], 1'b0};
            end
        end
    end

    // Next-state: op dispatch in idle, divider sequencing, flush/stall control
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        done_d    = 1'b0;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        a_neg     = (opcode == OpDiv) && A[31];
        b_neg     = (opcode == OpDiv) && B[31];

        if (is_flush) begin
            // Flush beats stall and divide completion; HI/LO untouched
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (issue) begin
                        case (opcode)
                            OpMult:  begin {hi_d, lo_d} = prod_s;       done_d = 1'b1; end
                            OpMultu: begin {hi_d, lo_d} = prod_u;       done_d = 1'b1; end
                            OpMadd:  begin {hi_d, lo_d} = acc + prod_s; done_d = 1'b1; end
                            OpMaddu: begin {hi_d, lo_d} = acc + prod_u; done_d = 1'b1; end
                            OpMsub:  begin {hi_d, lo_d} = acc - prod_s; done_d = 1'b1; end
                            OpMsubu: begin {hi_d, lo_d} = acc - prod_u; done_d = 1'b1; end
                            OpMthi:  begin hi_d = A;                    done_d = 1'b1; end
                            OpMtlo:  begin lo_d = A;                    done_d = 1'b1; end
                            OpMfhi:  begin result_d = hi_q;             done_d = 1'b1; end
                            OpMflo:  begin result_d = lo_q;             done_d = 1'b1; end
                            OpDiv, OpDivu: begin
                                if (B == 32'd0) begin
                                    // Divide by zero: no divide, just complete
                                    done_d = 1'b1;
                                end else begin
                                    quo_d     = a_neg ? -A : A;
                                    dvs_d     = b_neg ? -B : B;
                                    rem_d     = 32'd0;
                                    neg_quo_d = a_neg ^ b_neg;
                                    neg_rem_d = a_neg;
                                    cnt_d     = 6'd0;
                                    state_d   = StDivBusy;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StDivBusy: begin
                    if (!is_stall) begin
                        rem_d = step_rem;
                        quo_d = step_quo;
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == LastCnt) begin
                            state_d = StDivFix;
                        end
                    end
                end
                StDivFix: begin
                    if (!is_stall) begin
                        lo_d    = quo_fix;
                        hi_d    = rem_fix;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            result_q  <= 32'd0;
            stall_q   <= 1'b0;
            done_q    <= 1'b0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= 6'd0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            stall_q   <= (state_d != StIdle);
            done_q    <= done_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
        end
    end

    assign HI        = hi_q;
    assign LO        = lo_q;
    assign result    = result_q;
    assign ALU_Stall = stall_q;
    assign done      = done_q;

endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 SHALL have parameter: DIV_ITER, default 1, quotient bits resolved per divide cycle; legal values 1, 2, 4.
REQ-002 SHALL have port: clock  in  1  sole clock, rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: A  in  32  operand rs.
REQ-005 SHALL have port: B  in  32  operand rt.
REQ-006 SHALL have port: opcode  in  6  ALU opcode_list encoding: Div=5, Divu=6, Madd=7, Maddu=8, Mfhi=9, Mflo=10, Mthi=11, Mtlo=12, Msub=13, Msubu=14, Mult=16, Multu=17, EX_Stall=33, EX_Flush=34.
REQ-007 SHALL have port: issue  in  1  opcode/operands valid this cycle.
REQ-008 SHALL have port: result  out  32  registered Mfhi/Mflo data.
REQ-009 SHALL have port: HI  out  32  HI register.
REQ-010 SHALL have port: LO  out  32  LO register.
REQ-011 SHALL have port: ALU_Stall  out  1  divide in progress; requester holds issue/opcode.
REQ-012 SHALL have port: done  out  1  one-cycle completion pulse.

Function
REQ-013 SHALL accept an op only when issue=1 and state=IDLE; other opcodes are ignored with no state change.
REQ-014 SHALL ignore issue while state is DIV_BUSY or DIV_FIX, except for EX_Stall and EX_Flush.
REQ-015 SHALL, for Mult/Multu, write HI:LO <= signed/unsigned 64-bit A*B at the accepting edge.
REQ-016 SHALL, for Madd/Maddu and Msub/Msubu, write HI:LO <= HI:LO +/- product, with modulo 2^64 wrap and no overflow flag.
REQ-017 SHALL, for Mthi/Mtlo, write HI <= A or LO <= A respectively.
REQ-018 SHALL, for Mfhi/Mflo, write result <= HI or LO at the accepting edge; result SHALL hold its value otherwise.
REQ-019 SHALL complete every non-divide op in a single cycle with ALU_Stall=0; done=1 in the cycle after acceptance.
REQ-020 SHALL implement FSM states IDLE, DIV_BUSY, DIV_FIX; a Div/Divu with B!=0 SHALL move IDLE->DIV_BUSY.
REQ-021 SHALL iterate unsigned restoring division on magnitudes for 32/DIV_ITER cycles, then go DIV_BUSY->DIV_FIX.
REQ-022 SHALL, in DIV_FIX, apply sign correction, write LO=quotient and HI=remainder, and return to IDLE; done=1 in the following cycle.
REQ-023 SHALL, for Div, truncate the quotient toward zero and give the remainder the sign of the dividend; 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-024 SHALL, on divide by zero, start no divide, keep HI and LO unchanged, keep ALU_Stall=0, and pulse done.
REQ-025 SHALL hold ALU_Stall=1 from the cycle after divide acceptance through the DIV_FIX cycle inclusive; this is 32/DIV_ITER+1 cycles when no freezes occur.
REQ-026 SHALL, when issue=1 with EX_Stall in DIV_BUSY/DIV_FIX, freeze the divider that cycle; the stall window extends by one cycle.
REQ-027 SHALL, when issue=1 with EX_Flush in any state, abort any divide, keep HI and LO unchanged, enter IDLE next edge with ALU_Stall=0, and not pulse done.
REQ-028 SHALL give EX_Flush priority over EX_Stall and over divide completion in the same cycle.
REQ-029 SHALL keep HI, LO, and result stable between updates; all outputs SHALL be registered.

Reset
REQ-030 SHALL, while reset=1 (asynchronously), force result=0, HI=0, LO=0, ALU_Stall=0, done=0, state=IDLE, and clear divider registers.
REQ-031 SHALL abort a divide in progress on reset, leave no partial HI/LO update, and accept a new op on the first edge after deassertion.

Verification
REQ-032 SHALL be covered by: Mult A=0xFFFFFFFF B=2 -> HI=0xFFFFFFFF LO=0xFFFFFFFE; Multu same operands -> HI=0x00000001 LO=0xFFFFFFFE; no stall.
REQ-033 SHALL be covered by: Div A=0xFFFFFFF9 (-7) B=2, DIV_ITER=1 -> ALU_Stall high exactly 33 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF, done one pulse.
REQ-034 SHALL be covered by: Mtlo A=0xFFFFFFFF, Mthi A=0, Maddu A=1 B=1 -> HI=1 LO=0; Msubu A=1 B=1 -> HI=0 LO=0xFFFFFFFF; Mflo -> result=0xFFFFFFFF.
REQ-035 SHALL be covered by: Divu A=5 B=0 with HI=0x11 LO=0x22 -> HI/LO unchanged, ALU_Stall never high, done pulses once.
REQ-036 SHALL be covered by: Div A=100 B=7, EX_Stall on stall cycles 5-7, EX_Flush on cycle 20 -> ALU_Stall=0 next cycle, HI/LO unchanged, no done; an immediate Divu 100/7 -> LO=14 HI=2 after 33 stall cycles.
REQ-037 SHALL be covered by: reset asserted mid-clock on divide cycle 12 -> all outputs 0 immediately; Mult 3*4 after release -> LO=12 HI=0.
